// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud/acquisition tick generator with two-level fractional
// compensation. Error is spread first across the acquisition points of a
// bit (normal points, then compensated points) and then across the bits of
// a frame (POS bits are one clock per compensated point longer, NEG bits
// one clock shorter). Configuration is shadowed and only reloads at an
// enable start, on Restart_i, or at the end of a frame.
module uart_baud_gen #(
  parameter int CNT_W      = 13,
  parameter int OSR_W      = 4,
  parameter int FRAME_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BaudEn_i,
  input  logic                 Restart_i,
  input  logic [CNT_W-1:0]     AcqPeriod_i,
  input  logic [2*OSR_W-1:0]   PosComp_i,
  input  logic [2*OSR_W-1:0]   NegComp_i,
  input  logic [7:0]           FrameComp_i,
  output logic                 AcqSig_o,
  output logic                 BaudSig_o,
  output logic                 MidSig_o,
  output logic                 FrameSig_o,
  output logic [3:0]           BitIndex_o,
  output logic                 CfgErr_o
);
  localparam int PW = OSR_W + 1;   // point index / bit length width
  localparam int TW = CNT_W + 1;   // clock counter must reach P+1

  // Shadowed configuration. FrameComp is consumed straight into the
  // per-frame type counters at load time, so it needs no separate copy.
  logic [CNT_W-1:0]   r_per;
  logic [2*OSR_W-1:0] r_pos_cfg, r_neg_cfg;
  logic               r_err;

  logic               r_en_d;
  logic [TW-1:0]      r_cnt;
  logic [PW-1:0]      r_pt;
  logic [3:0]         r_bit, r_pos_left, r_neg_left;
  logic               r_acq, r_mid, r_baud, r_frm;

  logic               w_start, w_load, w_type_pos, w_in_comp;
  logic [2*OSR_W-1:0] w_comp;
  logic [PW-1:0]      w_hi, w_lo, w_len;
  logic [PW:0]        w_len1, w_mid_idx;
  logic [TW-1:0]      w_per_x, w_term;
  logic               w_pt_end, w_bit_end, w_mid, w_last_bit, w_frm_end;
  logic               w_err_nxt;

  // Decode the current bit type, point period and tick conditions
  always_comb begin
    w_start    = BaudEn_i & (~r_en_d | Restart_i);
    w_type_pos = r_pos_left > r_neg_left;   // tie selects NEG
    w_comp     = w_type_pos ? r_pos_cfg : r_neg_cfg;
    w_hi       = {1'b0, w_comp[2*OSR_W-1:OSR_W]};
    w_lo       = {1'b0, w_comp[OSR_W-1:0]};
    w_len      = w_hi + w_lo;
    w_in_comp  = r_pt >= w_hi;               // normal points come first
    w_per_x    = {1'b0, r_per};
    // Terminal count is period-1: normal P, POS comp P+1, NEG comp P-1
    w_term     = w_in_comp ? (w_type_pos ? w_per_x + TW'(1) : w_per_x - TW'(1))
                           : w_per_x;
    w_pt_end   = r_cnt == w_term;
    w_bit_end  = w_pt_end & (r_pt == w_len - PW'(1));
    w_len1     = {1'b0, w_len} + (PW+1)'(1);
    w_mid_idx  = (w_len1 >> 1) - (PW+1)'(1);
    w_mid      = w_pt_end & ({1'b0, r_pt} == w_mid_idx);
    w_last_bit = r_bit == 4'(FRAME_BITS-1);
    w_frm_end  = w_bit_end & w_last_bit;
    w_load     = w_start | w_frm_end;
    // Validity of the configuration about to be shadowed
    w_err_nxt  = (AcqPeriod_i == '0) | (PosComp_i == '0) | (NegComp_i == '0) |
                 (({1'b0, FrameComp_i[7:4]} + {1'b0, FrameComp_i[3:0]}) != 5'(FRAME_BITS));
  end

  // Shadow load, point/bit/type counters and registered tick outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per      <= '0;
      r_pos_cfg  <= '0;
      r_neg_cfg  <= '0;
      r_err      <= 1'b0;
      r_en_d     <= 1'b0;
      r_cnt      <= '0;
      r_pt       <= '0;
      r_bit      <= '0;
      r_pos_left <= '0;
      r_neg_left <= '0;
      r_acq      <= 1'b0;
      r_mid      <= 1'b0;
      r_baud     <= 1'b0;
      r_frm      <= 1'b0;
    end else if (!BaudEn_i) begin
      // Disabled: everything but the shadow returns to idle, no bit completion
      r_en_d     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_pt       <= '0;
      r_bit      <= '0;
      r_pos_left <= '0;
      r_neg_left <= '0;
      r_acq      <= 1'b0;
      r_mid      <= 1'b0;
      r_baud     <= 1'b0;
      r_frm      <= 1'b0;
    end else begin
      r_en_d <= 1'b1;
      if (w_load) begin
        r_per      <= AcqPeriod_i;
        r_pos_cfg  <= PosComp_i;
        r_neg_cfg  <= NegComp_i;
        r_pos_left <= FrameComp_i[7:4];
        r_neg_left <= FrameComp_i[3:0];
        r_err      <= w_err_nxt;
        r_bit      <= '0;
      end
      if (w_start) begin
        // Restart wins over any tick due at this edge
        r_cnt  <= '0;
        r_pt   <= '0;
        r_acq  <= 1'b0;
        r_mid  <= 1'b0;
        r_baud <= 1'b0;
        r_frm  <= 1'b0;
      end else begin
        // Ticks are gated by the error state that governed this frame
        r_acq  <= w_pt_end  & ~r_err;
        r_mid  <= w_mid     & ~r_err;
        r_baud <= w_bit_end & ~r_err;
        r_frm  <= w_frm_end & ~r_err;
        if (w_pt_end) begin
          r_cnt <= '0;
          r_pt  <= w_bit_end ? '0 : r_pt + PW'(1);
        end else begin
          r_cnt <= r_cnt + TW'(1);
        end
        if (w_bit_end && !w_last_bit) begin
          r_bit <= r_bit + 4'd1;
          if (w_type_pos) r_pos_left <= r_pos_left - 4'd1;
          else            r_neg_left <= r_neg_left - 4'd1;
        end
      end
    end
  end

  assign AcqSig_o   = r_acq;
  assign BaudSig_o  = r_baud;
  assign MidSig_o   = r_mid;
  assign FrameSig_o = r_frm;
  assign BitIndex_o = r_bit;
  assign CfgErr_o   = r_err;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: table of configurations with hand-computed frame
// lengths, directed corner sequences, then randomized traffic checked every
// cycle against a timeline model built from the frame-level rules.
module tb_uart_baud_gen;
  localparam int CNT_W = 13;
  localparam int OSR_W = 4;
  localparam int FB    = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1, en = 1'b0, rs = 1'b0;
  logic [CNT_W-1:0] per = '0;
  logic [7:0]       pc = '0, nc = '0, fc = '0;
  logic             acq, baud, mid, frm, err;
  logic [3:0]       bidx;

  int  n_run = 0, n_fail = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_baud_gen #(.CNT_W(CNT_W), .OSR_W(OSR_W), .FRAME_BITS(FB)) dut (
    .clk(clk), .rst(rst), .BaudEn_i(en), .Restart_i(rs),
    .AcqPeriod_i(per), .PosComp_i(pc), .NegComp_i(nc), .FrameComp_i(fc),
    .AcqSig_o(acq), .BaudSig_o(baud), .MidSig_o(mid), .FrameSig_o(frm),
    .BitIndex_o(bidx), .CfgErr_o(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-frame tick timeline ----------------
  int ev_t[$];
  bit ev_mid[$], ev_baud[$], ev_frm[$];
  int m_t, m_j, e_bit;
  bit m_prev, e_acq, e_mid, e_baud, e_frm, e_err;

  task automatic m_build();
    int pl, nl, acc, hi, lo, len;
    bit tp;
    ev_t.delete(); ev_mid.delete(); ev_baud.delete(); ev_frm.delete();
    e_err = (per == 0) || (pc == 0) || (nc == 0) ||
            (int'(fc[7:4]) + int'(fc[3:0]) != FB);
    m_t = 0; m_j = 0;
    if (!e_err) begin
      pl = int'(fc[7:4]); nl = int'(fc[3:0]); acc = 0;
      for (int b = 0; b < FB; b++) begin
        tp  = pl > nl;
        hi  = tp ? int'(pc[7:4]) : int'(nc[7:4]);
        lo  = tp ? int'(pc[3:0]) : int'(nc[3:0]);
        len = hi + lo;
        for (int p = 0; p < len; p++) begin
          acc += (p < hi) ? int'(per) + 1 : (tp ? int'(per) + 2 : int'(per));
          ev_t.push_back(acc);
          ev_mid.push_back(p == (len + 1) / 2 - 1);
          ev_baud.push_back(p == len - 1);
          ev_frm.push_back(p == len - 1 && b == FB - 1);
        end
        if (tp) pl--; else nl--;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    e_acq = 0; e_mid = 0; e_baud = 0; e_frm = 0;
    if (rst || !en) begin
      m_prev = 0; e_bit = 0; e_err = 0;
    end else begin
      if (!m_prev || rs) begin
        m_build(); e_bit = 0;
      end else if (!e_err) begin
        m_t++;
        if (m_t == ev_t[m_j]) begin
          e_acq = 1; e_mid = ev_mid[m_j]; e_baud = ev_baud[m_j]; e_frm = ev_frm[m_j];
          if (e_baud) e_bit = e_frm ? 0 : e_bit + 1;
          if (e_frm) m_build(); else m_j++;
        end
      end
      m_prev = 1;
    end
    #1;
    if (chk_en) begin
      chk("rand_ticks_err", {acq, mid, baud, frm, err}, {e_acq, e_mid, e_baud, e_frm, e_err});
      if (!e_err) chk("rand_bitidx", bidx, e_bit);
    end
  end

  // ---------------- helpers ----------------
  task automatic restart_cfg(input int p, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    per = CNT_W'(p); pc = a; nc = b; fc = c; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
  endtask

  // Counts edges until the selected tick is seen (0 acq,1 baud,2 mid,3 frame)
  task automatic wait_ev(input int sel, input int lim, output int n);
    logic [3:0] v;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      v = {frm, mid, baud, acq};
    end while (!v[sel] && n <= lim);
  endtask

  task automatic wait_bit(input logic [3:0] b);
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (bidx != b && t < 3000);
    chk("wait_bitidx", bidx, b);
  endtask

  task automatic rand_cfg(input bit ok);
    int h, l, pp;
    per = CNT_W'($urandom_range(1, 5));
    h = $urandom_range(0, 5); l = $urandom_range(0, 5); if (h + l == 0) l = 1;
    pc = {4'(h), 4'(l)};
    h = $urandom_range(0, 5); l = $urandom_range(0, 5); if (h + l == 0) l = 1;
    nc = {4'(h), 4'(l)};
    pp = $urandom_range(0, 11);
    fc = {4'(pp), 4'(11 - pp)};
    if (!ok) begin
      case ($urandom_range(0, 3))
        0:       per = '0;
        1:       pc  = '0;
        2:       nc  = '0;
        default: fc  = {4'(pp), 4'(12 - pp)};
      endcase
    end
  endtask

  typedef struct {
    int         p;
    logic [7:0] pc, nc, fc;
    bit         err;
    int         flen;
  } vec_t;
  vec_t tv[9];

  initial begin
    int n, n2, ticks, cnt, t;
    int at[24];
    bit md[24], bd[24];
    int gap[8];
    bit ok;

    tv[0] = '{3, 8'h62, 8'h71, 8'h56, 1'b0, 356};
    tv[1] = '{3, 8'h62, 8'h71, 8'h55, 1'b1, 0};
    tv[2] = '{0, 8'h62, 8'h71, 8'h56, 1'b1, 0};
    tv[3] = '{3, 8'h00, 8'h71, 8'h56, 1'b1, 0};
    tv[4] = '{1, 8'h10, 8'h01, 8'hB0, 1'b0, 22};
    tv[5] = '{2, 8'h01, 8'h10, 8'h0B, 1'b0, 33};
    tv[6] = '{3, 8'h62, 8'h00, 8'h56, 1'b1, 0};
    tv[7] = '{5, 8'h33, 8'h24, 8'h38, 1'b0, 373};
    tv[8] = '{1, 8'hFF, 8'hFF, 8'h65, 1'b0, 675};
    gap   = '{4, 4, 4, 4, 4, 4, 5, 5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {acq, mid, baud, frm, err, bidx}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {acq, mid, baud, frm, err, bidx}, 0);
    en = 1'b1;

    // Configuration table: error flag and restart-to-frame-end length
    for (int i = 0; i < 9; i++) begin
      restart_cfg(tv[i].p, tv[i].pc, tv[i].nc, tv[i].fc);
      chk($sformatf("cfgerr_v%0d", i), err, tv[i].err);
      if (tv[i].err) begin
        ticks = 0;
        repeat (800) begin @(posedge clk); #1; if (acq | mid | baud | frm) ticks++; end
        chk($sformatf("noticks_v%0d", i), ticks, 0);
      end else begin
        wait_ev(3, 2000, n);
        chk($sformatf("framelen_v%0d", i), n, tv[i].flen);
        chk($sformatf("frame_bitidx_v%0d", i), bidx, 0);
      end
    end

    // Per-point pattern of the first POS bit (bit 2) of the basic config
    restart_cfg(3, 8'h62, 8'h71, 8'h56);
    cnt = 0; t = 0;
    while (cnt < 24 && t < 1000) begin
      @(posedge clk); #1; t++;
      if (acq) begin at[cnt] = t; md[cnt] = mid; bd[cnt] = baud; cnt++; end
    end
    chk("pattern_acq_count", cnt, 24);
    chk("first_acq_delay", at[0], 4);
    for (int k = 16; k < 24; k++) begin
      chk($sformatf("pos_gap_%0d", k - 16), at[k] - at[k-1], gap[k-16]);
      chk($sformatf("pos_mid_baud_%0d", k - 16), {md[k], bd[k]}, {k == 19, k == 23});
    end

    // Restart at an edge where an acquisition tick was due (bit 5)
    restart_cfg(3, 8'h62, 8'h71, 8'h56);
    wait_bit(4'd5);
    chk("bit5_entry_acq", acq, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); rs = 1'b1;
    @(posedge clk); #1;
    chk("restart_suppress", {acq, mid, baud, frm, bidx}, 0);
    @(negedge clk); rs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("restart_acq_%0d", k), acq, k == 4);
    end

    // Shadowing: mid-frame FrameComp change applies at the next frame
    restart_cfg(3, 8'h62, 8'h71, 8'h56);
    repeat (100) @(negedge clk);
    fc = 8'h65;
    wait_ev(3, 2000, n);
    chk("shadow_cur_frame", n + 100, 356);
    wait_ev(1, 200, n);
    chk("shadow_first_bit_pos", n, 34);
    wait_ev(3, 2000, n2);
    chk("shadow_next_frame", n + n2, 359);

    // Asynchronous reset mid-frame
    restart_cfg(3, 8'h62, 8'h71, 8'h56);
    wait_bit(4'd3);
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", {acq, mid, baud, frm, err, bidx}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    wait_ev(0, 100, n);
    chk("rst_reenable_acq", n, 4);
    wait_ev(3, 2000, n2);
    chk("rst_reenable_frame", n + n2, 356);

    // One-cycle enable drop mid-frame
    wait_bit(4'd3);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("disable_outputs", {acq, mid, baud, frm, err, bidx}, 0);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    wait_ev(0, 100, n);
    chk("en_reenable_acq", n, 4);
    wait_ev(1, 200, n2);
    chk("en_reenable_bit0", n + n2, 31);
    chk("en_reenable_bitidx", bidx, 1);

    // Randomized traffic against the timeline model
    @(negedge clk);
    chk_en = 1'b1;
    for (int s = 0; s < 16; s++) begin
      ok = $urandom_range(0, 4) != 0;
      rand_cfg(ok);
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        en = 1'b1;
      end else begin
        rs = 1'b1;
      end
      @(negedge clk);
      rs = 1'b0;
      repeat ($urandom_range(200, 2000)) begin
        @(negedge clk);
        if (ok && $urandom_range(0, 199) == 0) rand_cfg(1'b1);
        rs = ($urandom_range(0, 399) == 0);
      end
      rs = 1'b0;
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
